demosaic_bilinear: RTL and testbench
====================================

# demosaic_bilinear

Bilinear Bayer-to-RGB demosaic stage that sits directly upstream of the AWB stage. It accepts an 8-bit raw Bayer stream with vsync/hsync/den timing and emits 8-bit R/G/B planes on an identically shaped, delayed timing stream, which feeds the AWB inputs directly. It uses two line buffers and a 3x3 window, with a fixed pipeline latency.

## Interface
- source_h, 512: active pixels per line; sets line-buffer depth and column-counter range.
- source_v, 512: active lines per frame; sets row-counter range.
- BAYER_PATTERN, 0: CFA phase of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
- clk  in  1  sole clock; all logic is on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_vsync  in  1  frame sync; its rising edge marks frame start.
- in_hsync  in  1  line sync; delayed only, not interpreted.
- in_den  in  1  pixel valid.
- in_data  in  8  raw Bayer sample.
- bypass  in  1  raw-to-gray bypass; present only with DEMOSAIC_BYPASS_EN.
- out_vsync, out_hsync, out_den  out  1 each  input timing delayed by 2 cycles.
- out_data_R, out_data_G, out_data_B  out  8 each  interpolated pixel.

## Operation
- Counters:
  - col (0..source_h-1) increments on each in_den cycle and clears on the in_den falling edge.
  - row (0..source_v-1) increments on the in_den falling edge and clears on the in_vsync rising edge.
  - Neither counter wraps past its maximum; each saturates.
- Line buffers: two source_h x 8 simple-dual-port RAMs, read-before-write at address col on in_den.
  - lb1 holds row-1; lb2 holds row-2.
  - The cycle's input is written to lb1, and lb1's old value is written to lb2.
- Window: a 3x3 register array shifts one column per in_den cycle.
  - Columns are col, col-1, col-2; rows are row-2, row-1, row.
  - Centre pixel is (row-1, col-1). The output image is therefore shifted one line down and one pixel right.
- Site type comes from the parities of the centre row and column, combined with BAYER_PATTERN.
- Interpolation (all sums floor-divided; widths 10 bits for 4-term sums, 9 bits for 2-term sums):
  - R site: R=C, G=(N+S+E+W)>>2, B=(NW+NE+SW+SE)>>2.
  - B site: mirror of the R site.
  - G site on an R row: G=C, R=(W+E)>>1, B=(N+S)>>1.
  - G site on a B row: G=C, B=(W+E)>>1, R=(N+S)>>1.
- Borders:
  - Output row 0 and output column 0 are forced to R=G=B=0.
  - At centre row 0, N is replaced by S. At centre column 0, W is replaced by E, with NW/SW mirrored the same way.
  - The last input row and last input column never appear as a centre.
- Sync gate: after reset release, a `synced` flag is 0 and all output data is 0 until the first in_vsync rising edge. Timing outputs still propagate during this period.

## Timing
- Latency: in_* at edge t appears on out_* at edge t+2.
  - Stage 1: window/line-buffer shift.
  - Stage 2: arithmetic plus output register.
- No backpressure; the stage accepts one pixel per cycle continuously.
- Reset values: all outputs 0, counters 0, window 0, synced 0. RAM contents are not reset.
- Reset asserted mid-frame: outputs go to 0 asynchronously. After release, output data stays 0 until the next vsync rising edge.
- vsync rising edge in the same cycle as in_den: row clears first, and the pixel is treated as row 0.
- in_den falling edge at col < source_h-1 (short line): row still increments, and the remaining RAM entries keep stale data.

## Configuration
- DEMOSAIC_BYPASS_EN defined: adds the `bypass` port.
  - `bypass` is sampled on the in_vsync rising edge and held for the whole frame.
  - When the held value is 1: R=G=B=centre raw value, with the same 2-cycle latency and the same border zeroing.
- DEMOSAIC_BYPASS_EN undefined: no `bypass` port; the stage always demosaics.

## Structure
- Shared package isp_pkg holds:
  - BAYER_RGGB/GRBG/GBRG/BGGR constants.
  - the pixel width constant (8).
  - the site-type encoding (R, GR, GB, B).
- Sub-module demosaic_linebuf: one parameterised RAM (depth source_h, width 8, read-before-write), instantiated twice.

## Test plan
- Uniform raw 100 on an 8x8 frame, RGGB -> every pixel outside row 0/col 0 outputs (100,100,100); row 0 and col 0 output (0,0,0).
- RGGB, R sites=200, G sites=100, B sites=50 -> every interior output is (200,100,50), at all four site types.
- R-site centre 40 with N=10, S=20, E=30, W=41 -> G=25 (floor of 101/4).
- Single isolated in_den pulse with in_hsync/in_vsync toggles -> out_den/out_hsync/out_vsync reproduce the waveform exactly 2 cycles later.
- reset_n pulled low at row 3, col 5 -> outputs read 0 within the same cycle. After release, out_den follows in_den and data stays 0 until the next vsync rising edge; the following frame is correct.
- DEMOSAIC_BYPASS_EN, bypass raised mid-frame, raw 77 -> current frame stays demosaiced; the next frame outputs (77,77,77).

Source files
------------

// File: rtl/isp_pkg.sv
// isp_pkg: constants and Bayer site encoding shared by the ISP stages.
package isp_pkg;

    localparam int PIX_W = 8;

    localparam int BAYER_RGGB = 0;
    localparam int BAYER_GRBG = 1;
    localparam int BAYER_GBRG = 2;
    localparam int BAYER_BGGR = 3;

    typedef enum logic [1:0] {
        SITE_R  = 2'd0,
        SITE_GR = 2'd1,
        SITE_GB = 2'd2,
        SITE_B  = 2'd3
    } site_t;

    // Pattern bit 1 flips row parity, bit 0 flips column parity (vs RGGB).
    function automatic site_t site_of(
        input logic       row_odd,
        input logic       col_odd,
        input logic [1:0] pattern
    );
        return site_t'({row_odd ^ pattern[1], col_odd ^ pattern[0]});
    endfunction

endpackage

// File: rtl/demosaic_linebuf.sv
// demosaic_linebuf: one line of pixel storage, async read, sync write.
// A read in the same cycle as a write at that address returns the old word.
module demosaic_linebuf
    import isp_pkg::*;
#(
    parameter  int DEPTH = 512,
    parameter  int WIDTH = PIX_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/demosaic_bilinear.sv
// demosaic_bilinear: 3x3 bilinear Bayer-to-RGB, two-cycle pipeline.
// Define DEMOSAIC_BYPASS_EN to add the frame-latched raw-to-gray bypass.
module demosaic_bilinear
    import isp_pkg::*;
#(
    parameter int source_h      = 512,
    parameter int source_v      = 512,
    parameter int BAYER_PATTERN = BAYER_RGGB
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_vsync,
    input  logic             in_hsync,
    input  logic             in_den,
    input  logic [PIX_W-1:0] in_data,
`ifdef DEMOSAIC_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             out_vsync,
    output logic             out_hsync,
    output logic             out_den,
    output logic [PIX_W-1:0] out_data_R,
    output logic [PIX_W-1:0] out_data_G,
    output logic [PIX_W-1:0] out_data_B
);

    localparam int CW = (source_h > 1) ? $clog2(source_h) : 1;
    localparam int RW = (source_v > 1) ? $clog2(source_v) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(source_h - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(source_v - 1);
    localparam logic [1:0]    PAT     = 2'(BAYER_PATTERN);

    logic             den_d, vs_d, synced;
    logic             vs_rise, den_fall;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row, row_eff;
    logic [PIX_W-1:0] lb1_q, lb2_q;
    logic [PIX_W-1:0] win [3][3];

    assign vs_rise  = in_vsync & ~vs_d;
    assign den_fall = ~in_den & den_d;
    // A pixel arriving with the vsync edge already belongs to row 0.
    assign row_eff  = vs_rise ? '0 : row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            den_d  <= 1'b0;
            vs_d   <= 1'b0;
            synced <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else begin
            den_d <= in_den;
            vs_d  <= in_vsync;
            if (vs_rise) synced <= 1'b1;
            if (den_fall) col <= '0;
            else if (in_den && col != COL_MAX) col <= col + 1'b1;
            if (vs_rise) row <= '0;
            else if (den_fall && row != ROW_MAX) row <= row + 1'b1;
        end
    end

    demosaic_linebuf #(.DEPTH(source_h), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (in_den),
        .addr  (col),
        .wdata (in_data),
        .rdata (lb1_q)
    );

    demosaic_linebuf #(.DEPTH(source_h), .WIDTH(PIX_W)) u_lb2 (
        .clk   (clk),
        .we    (in_den),
        .addr  (col),
        .wdata (lb1_q),
        .rdata (lb2_q)
    );

    // Row 0 = row-2, row 2 = current; column 0 = newest (east).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (in_den) begin
            for (int r = 0; r < 3; r++) begin
                win[r][2] <= win[r][1];
                win[r][1] <= win[r][0];
            end
            win[0][0] <= lb2_q;
            win[1][0] <= lb1_q;
            win[2][0] <= in_data;
        end
    end

    logic s1_vs, s1_hs, s1_den, s1_edge;
    logic s1_top, s1_left, s1_row_odd, s1_col_odd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vs      <= 1'b0;
            s1_hs      <= 1'b0;
            s1_den     <= 1'b0;
            s1_edge    <= 1'b0;
            s1_top     <= 1'b0;
            s1_left    <= 1'b0;
            s1_row_odd <= 1'b0;
            s1_col_odd <= 1'b0;
        end else begin
            s1_vs      <= in_vsync;
            s1_hs      <= in_hsync;
            s1_den     <= in_den;
            s1_edge    <= (row_eff == '0) || (col == '0);
            s1_top     <= (row_eff == RW'(1));
            s1_left    <= (col == CW'(1));
            s1_row_odd <= ~row_eff[0];
            s1_col_odd <= ~col[0];
        end
    end

`ifdef DEMOSAIC_BYPASS_EN
    logic byp, s1_byp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp    <= 1'b0;
            s1_byp <= 1'b0;
        end else begin
            if (vs_rise) byp <= bypass;
            s1_byp <= vs_rise ? bypass : byp;
        end
    end
`endif

    // Mirror the missing top row / west column onto the opposite side.
    logic [PIX_W-1:0] m [3][3];

    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = win[r][c];
        if (s1_top)
            for (int c = 0; c < 3; c++)
                m[0][c] = win[2][c];
        if (s1_left)
            for (int r = 0; r < 3; r++)
                m[r][2] = m[r][0];
    end

    logic [9:0]       cross4, diag4;
    logic [8:0]       horz2, vert2;
    logic [PIX_W-1:0] cen, r_px, g_px, b_px;
    site_t            site;

    assign cen    = m[1][1];
    assign cross4 = 10'(m[0][1]) + 10'(m[2][1])
                  + 10'(m[1][0]) + 10'(m[1][2]);
    assign diag4  = 10'(m[0][0]) + 10'(m[0][2])
                  + 10'(m[2][0]) + 10'(m[2][2]);
    assign horz2  = 9'(m[1][0]) + 9'(m[1][2]);
    assign vert2  = 9'(m[0][1]) + 9'(m[2][1]);
    assign site   = site_of(s1_row_odd, s1_col_odd, PAT);

    always_comb begin
        r_px = cen;
        g_px = cen;
        b_px = cen;
        unique case (site)
            SITE_R: begin
                g_px = PIX_W'(cross4 >> 2);
                b_px = PIX_W'(diag4 >> 2);
            end
            SITE_B: begin
                g_px = PIX_W'(cross4 >> 2);
                r_px = PIX_W'(diag4 >> 2);
            end
            SITE_GR: begin
                r_px = PIX_W'(horz2 >> 1);
                b_px = PIX_W'(vert2 >> 1);
            end
            SITE_GB: begin
                b_px = PIX_W'(horz2 >> 1);
                r_px = PIX_W'(vert2 >> 1);
            end
        endcase
`ifdef DEMOSAIC_BYPASS_EN
        if (s1_byp) begin
            r_px = cen;
            g_px = cen;
            b_px = cen;
        end
`endif
    end

    logic zero;
    assign zero = ~synced | s1_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vsync  <= 1'b0;
            out_hsync  <= 1'b0;
            out_den    <= 1'b0;
            out_data_R <= '0;
            out_data_G <= '0;
            out_data_B <= '0;
        end else begin
            out_vsync  <= s1_vs;
            out_hsync  <= s1_hs;
            out_den    <= s1_den;
            out_data_R <= zero ? '0 : r_px;
            out_data_G <= zero ? '0 : g_px;
            out_data_B <= zero ? '0 : b_px;
        end
    end

endmodule

// File: tb/tb_demosaic_bilinear.sv
// tb_demosaic_bilinear: scoreboard bench for the bilinear demosaic stage.
// Build with DEMOSAIC_BYPASS_EN defined to also cover the bypass frames.
module tb_demosaic_bilinear;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_vsync = 1'b0;
    logic       in_hsync = 1'b0;
    logic       in_den = 1'b0;
    logic [7:0] in_data = 8'h0;
    logic       bypass = 1'b0;
    logic       out_vsync, out_hsync, out_den;
    logic [7:0] out_data_R, out_data_G, out_data_B;

    int checks = 0;
    int errors = 0;
    int fid = 0;
    bit mdl_synced = 1'b0;
    bit mdl_byp = 1'b0;
    bit last_vs = 1'b0;
    logic [2:0] h0 = 3'b0;
    logic [2:0] h1 = 3'b0;
    logic [7:0] img [H][W];
    logic [23:0] exp_q [$];
    int tag_q [$];

    demosaic_bilinear #(
        .source_h      (W),
        .source_v      (H),
        .BAYER_PATTERN (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_vsync   (in_vsync),
        .in_hsync   (in_hsync),
        .in_den     (in_den),
        .in_data    (in_data),
`ifdef DEMOSAIC_BYPASS_EN
        .bypass     (bypass),
`endif
        .out_vsync  (out_vsync),
        .out_hsync  (out_hsync),
        .out_den    (out_den),
        .out_data_R (out_data_R),
        .out_data_G (out_data_G),
        .out_data_B (out_data_B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference neighbourhood: rows/cols before 0 reflect about the edge.
    function automatic int px(int y, int x);
        if (y < 0) y = -y;
        if (x < 0) x = -x;
        return int'(img[y][x]);
    endfunction

    // Output that accompanies input pixel (r,c): centre is (r-1,c-1).
    function automatic logic [23:0] expect_px(int r, int c);
        int y, x, cc, cr4, dg4, h2, v2, rr, gg, bb;
        if (!mdl_synced || r == 0 || c == 0) return 24'h0;
        y = r - 1;
        x = c - 1;
        cc  = px(y, x);
        cr4 = (px(y-1, x) + px(y+1, x) + px(y, x-1) + px(y, x+1)) / 4;
        dg4 = (px(y-1, x-1) + px(y-1, x+1)
             + px(y+1, x-1) + px(y+1, x+1)) / 4;
        h2  = (px(y, x-1) + px(y, x+1)) / 2;
        v2  = (px(y-1, x) + px(y+1, x)) / 2;
        if (mdl_byp) begin
            rr = cc; gg = cc; bb = cc;
        end else begin
            case ((y % 2) * 2 + (x % 2))
                0: begin rr = cc;  gg = cr4; bb = dg4; end
                1: begin rr = h2;  gg = cc;  bb = v2;  end
                2: begin rr = v2;  gg = cc;  bb = h2;  end
                default: begin rr = dg4; gg = cr4; bb = cc; end
            endcase
        end
        return {rr[7:0], gg[7:0], bb[7:0]};
    endfunction

    // Drive one cycle; check the outputs of the cycle driven 2 steps ago.
    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [7:0] d, input logic [23:0] ex,
                        input int tag);
        logic [23:0] e;
        int t;
        in_vsync = vs;
        in_hsync = hs;
        in_den   = de;
        in_data  = d;
        if (vs && !last_vs) begin
            mdl_synced = 1'b1;
            mdl_byp    = bypass;
        end
        last_vs = vs;
        if (de) begin
            exp_q.push_back(ex);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        chk("out_vsync", out_vsync, h1[2]);
        chk("out_hsync", out_hsync, h1[1]);
        chk("out_den", out_den, h1[0]);
        if (h1[0]) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk($sformatf("R f%0d p%0d", fid, t), out_data_R, e[23:16]);
                chk($sformatf("G f%0d p%0d", fid, t), out_data_G, e[15:8]);
                chk($sformatf("B f%0d p%0d", fid, t), out_data_B, e[7:0]);
                if (fid == 3 && t == 303)
                    chk("g_floor", out_data_G, 25);
            end
        end
        h1 = h0;
        h0 = {vs, hs, de};
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_vsync"}, out_vsync, 0);
        chk({pfx, "_hsync"}, out_hsync, 0);
        chk({pfx, "_den"}, out_den, 0);
        chk({pfx, "_R"}, out_data_R, 0);
        chk({pfx, "_G"}, out_data_G, 0);
        chk({pfx, "_B"}, out_data_B, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        in_den = 1'b0;
        in_vsync = 1'b0;
        in_hsync = 1'b0;
        exp_q.delete();
        tag_q.delete();
        h0 = 3'b0;
        h1 = 3'b0;
        mdl_synced = 1'b0;
        mdl_byp = 1'b0;
        last_vs = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_frame(input int rst_r, input int byp_r);
        fid++;
        step(1, 0, 0, 8'h0, 24'h0, 0);
        step(0, 0, 0, 8'h0, 24'h0, 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == rst_r && c == 5) do_reset();
                if (r == byp_r && c == 0) bypass = 1'b1;
                step(0, 0, 1, img[r][c], expect_px(r, c), r * 100 + c);
            end
            step(0, 1, 0, 8'h0, 24'h0, 0);
            step(0, 0, 0, 8'h0, 24'h0, 0);
        end
        step(0, 0, 0, 8'h0, 24'h0, 0);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'd100;
        run_frame(-1, -1);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (r % 2 == 0 && c % 2 == 0) ? 8'd200 :
                            (r % 2 == 1 && c % 2 == 1) ? 8'd50 : 8'd100;
        run_frame(-1, -1);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'd0;
        img[2][2] = 8'd40;
        img[1][2] = 8'd10;
        img[3][2] = 8'd20;
        img[2][3] = 8'd30;
        img[2][1] = 8'd41;
        run_frame(-1, -1);

        // Isolated pulses with sync toggles; both pixels sit at col 0.
        step(0, 0, 0, 8'h0, 24'h0, 0);
        step(0, 1, 0, 8'h0, 24'h0, 0);
        step(0, 0, 1, 8'h9c, 24'h0, 900);
        step(0, 1, 0, 8'h0, 24'h0, 0);
        step(1, 0, 0, 8'h0, 24'h0, 0);
        step(0, 0, 0, 8'h0, 24'h0, 0);
        step(1, 1, 1, 8'h55, 24'h0, 901);
        step(0, 0, 0, 8'h0, 24'h0, 0);
        step(0, 1, 0, 8'h0, 24'h0, 0);
        step(0, 0, 0, 8'h0, 24'h0, 0);

        fill_rand();
        run_frame(3, -1);
        fill_rand();
        run_frame(-1, -1);

`ifdef DEMOSAIC_BYPASS_EN
        fill_rand();
        run_frame(-1, 4);
        fill_rand();
        run_frame(-1, -1);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
